// File: rtl/learn_judge.sv
// Judges each expected note as hit or miss within a timing window, keeps
// saturating hit/miss/streak statistics, a streak-driven level and a final grade.
module learn_judge #(
   parameter int unsigned WINDOW_CYCLES   = 50_000_000,
   parameter int unsigned CNT_W           = 8,
   parameter int unsigned LEVEL_UP_STREAK = 8,
   parameter int unsigned MAX_LEVEL       = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             note_valid,
   input  logic [3:0]       note_exp,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   input  logic             song_done,
   output logic             hit,
   output logic             miss,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] streak,
   output logic [CNT_W-1:0] max_streak,
   output logic [3:0]       level,
   output logic [2:0]       grade,
   output logic             busy
);

   localparam int unsigned TMR_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int unsigned GW    = CNT_W + 3;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, WAIT_KEY, DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       note_q, note_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             hit_q, hit_d, miss_q, miss_d;
   logic [CNT_W-1:0] hit_count_q, hit_count_d;
   logic [CNT_W-1:0] miss_count_q, miss_count_d;
   logic [CNT_W-1:0] streak_q, streak_d;
   logic [CNT_W-1:0] max_streak_q, max_streak_d;
   logic [3:0]       level_q, level_d;
   logic [2:0]       grade_q, grade_d;

   logic             judge_hit, judge_miss;
   logic [CNT_W-1:0] streak_inc;
   logic [GW-1:0]    tot_w, hit_w;
   logic [2:0]       grade_calc;

   // Grade thresholds use shifted integer compares instead of a divide.
   always_comb begin
      hit_w = GW'(hit_count_q);
      tot_w = GW'(hit_count_q) + GW'(miss_count_q);
      if (tot_w == '0)                            grade_calc = 3'd0;
      else if (hit_w == tot_w)                    grade_calc = 3'd5;
      else if ((hit_w << 2) >= (tot_w << 1) + tot_w) grade_calc = 3'd4;
      else if ((hit_w << 1) >= tot_w)             grade_calc = 3'd3;
      else if ((hit_w << 2) >= tot_w)             grade_calc = 3'd2;
      else                                        grade_calc = 3'd1;
   end

   always_comb begin
      state_d      = state_q;
      note_d       = note_q;
      timer_d      = timer_q;
      hit_d        = 1'b0;
      miss_d       = 1'b0;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      streak_d     = streak_q;
      max_streak_d = max_streak_q;
      level_d      = level_q;
      grade_d      = grade_q;
      judge_hit    = 1'b0;
      judge_miss   = 1'b0;
      streak_inc   = (streak_q == CNT_MAX) ? streak_q : streak_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (song_done) begin
               state_d = DONE;
            end else if (note_valid) begin
               note_d  = note_exp;
               timer_d = '0;
               state_d = WAIT_KEY;
            end
         end
         WAIT_KEY: begin
            timer_d = timer_q + 1'b1;
            // A key is judged unless a new note arrives on the same cycle.
            if (key_valid && !note_valid) begin
               judge_hit  = (key_code == note_q);
               judge_miss = (key_code != note_q);
            end else if (note_valid || song_done ||
                         timer_q == TMR_W'(WINDOW_CYCLES - 1)) begin
               judge_miss = 1'b1;
            end
            if (song_done) begin
               state_d = DONE;
            end else if (note_valid) begin
               note_d  = note_exp;
               timer_d = '0;
            end else if (judge_hit || judge_miss) begin
               state_d = IDLE;
            end
         end
         DONE: grade_d = grade_calc;
         default: state_d = IDLE;
      endcase

      if (judge_hit) begin
         hit_d       = 1'b1;
         hit_count_d = (hit_count_q == CNT_MAX) ? hit_count_q : hit_count_q + 1'b1;
         streak_d    = streak_inc;
         if (streak_inc > max_streak_q) max_streak_d = streak_inc;
         if ((32'(streak_inc) % LEVEL_UP_STREAK) == 32'd0 && level_q < 4'(MAX_LEVEL))
            level_d = level_q + 1'b1;
      end
      if (judge_miss) begin
         miss_d       = 1'b1;
         miss_count_d = (miss_count_q == CNT_MAX) ? miss_count_q : miss_count_q + 1'b1;
         streak_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         note_q       <= '0;
         timer_q      <= '0;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
         streak_q     <= '0;
         max_streak_q <= '0;
         level_q      <= '0;
         grade_q      <= '0;
      end else begin
         state_q      <= state_d;
         note_q       <= note_d;
         timer_q      <= timer_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         streak_q     <= streak_d;
         max_streak_q <= max_streak_d;
         level_q      <= level_d;
         grade_q      <= grade_d;
      end
   end

   assign hit        = hit_q;
   assign miss       = miss_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
   assign streak     = streak_q;
   assign max_streak = max_streak_q;
   assign level      = level_q;
   assign grade      = grade_q;
   assign busy       = (state_q == WAIT_KEY);

endmodule

// File: tb/tb_learn_judge.sv
// Bench for learn_judge: two instances (8-bit and 3-bit counters) driven alike,
// checked every cycle against a deadline-based note model plus literal checkpoints.
module tb_learn_judge;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       note_valid = 1'b0, key_valid = 1'b0, song_done = 1'b0;
   logic [3:0] note_exp = '0, key_code = '0;

   logic       hit0, miss0, busy0, hit1, miss1, busy1;
   logic [7:0] hc0, mc0, st0, mx0;
   logic [2:0] hc1, mc1, st1, mx1;
   logic [3:0] lv0, lv1;
   logic [2:0] gr0, gr1;

   int total = 0;
   int bad   = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   learn_judge #(.WINDOW_CYCLES(16), .CNT_W(8), .LEVEL_UP_STREAK(8), .MAX_LEVEL(9)) u_dut0 (
      .clk(clk), .rst(rst), .note_valid(note_valid), .note_exp(note_exp),
      .key_valid(key_valid), .key_code(key_code), .song_done(song_done),
      .hit(hit0), .miss(miss0), .hit_count(hc0), .miss_count(mc0), .streak(st0),
      .max_streak(mx0), .level(lv0), .grade(gr0), .busy(busy0));

   learn_judge #(.WINDOW_CYCLES(16), .CNT_W(3), .LEVEL_UP_STREAK(8), .MAX_LEVEL(9)) u_dut1 (
      .clk(clk), .rst(rst), .note_valid(note_valid), .note_exp(note_exp),
      .key_valid(key_valid), .key_code(key_code), .song_done(song_done),
      .hit(hit1), .miss(miss1), .hit_count(hc1), .miss_count(mc1), .streak(st1),
      .max_streak(mx1), .level(lv1), .grade(gr1), .busy(busy1));

   // Model: a pending note has a deadline cycle; counters are plain ints clipped to a limit.
   int lim[2] = '{255, 7};
   int m_hc[2], m_mc[2], m_st[2], m_mx[2], m_lv[2], m_gr[2];
   int m_hit, m_miss, m_pend, m_done, m_exp, m_dl, cyc, verdict;

   function automatic int grade_of(input int h, input int m);
      int t;
      t = h + m;
      if (t == 0)         return 0;
      if (h == t)         return 5;
      if (4 * h >= 3 * t) return 4;
      if (2 * h >= t)     return 3;
      if (4 * h >= t)     return 2;
      return 1;
   endfunction

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   always @(posedge clk) begin
      m_hit  = 0;
      m_miss = 0;
      if (rst) begin
         m_pend = 0;
         m_done = 0;
         for (int k = 0; k < 2; k++) begin
            m_hc[k] = 0; m_mc[k] = 0; m_st[k] = 0; m_mx[k] = 0; m_lv[k] = 0; m_gr[k] = 0;
         end
      end else if (m_done != 0) begin
         for (int k = 0; k < 2; k++) m_gr[k] = grade_of(m_hc[k], m_mc[k]);
      end else begin
         verdict = 0;
         if (m_pend != 0) begin
            if (key_valid && !note_valid)
               verdict = (int'(key_code) == m_exp) ? 1 : 2;
            else if (note_valid || song_done || cyc == m_dl)
               verdict = 2;
         end
         if (verdict == 1) begin
            m_hit = 1;
            for (int k = 0; k < 2; k++) begin
               m_hc[k] = min2(m_hc[k] + 1, lim[k]);
               m_st[k] = min2(m_st[k] + 1, lim[k]);
               if (m_st[k] > m_mx[k]) m_mx[k] = m_st[k];
               if (m_st[k] % 8 == 0) m_lv[k] = min2(m_lv[k] + 1, 9);
            end
         end else if (verdict == 2) begin
            m_miss = 1;
            for (int k = 0; k < 2; k++) begin
               m_mc[k] = min2(m_mc[k] + 1, lim[k]);
               m_st[k] = 0;
            end
         end
         if (song_done) begin
            m_done = 1;
            m_pend = 0;
         end else if (note_valid) begin
            m_pend = 1;
            m_exp  = int'(note_exp);
            m_dl   = cyc + 16;
         end else if (verdict != 0) begin
            m_pend = 0;
         end
      end
      cyc++;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("hit0", int'(hit0), m_hit);        chk("hit1", int'(hit1), m_hit);
         chk("miss0", int'(miss0), m_miss);     chk("miss1", int'(miss1), m_miss);
         chk("busy0", int'(busy0), m_pend);     chk("busy1", int'(busy1), m_pend);
         chk("hit_count0", int'(hc0), m_hc[0]); chk("hit_count1", int'(hc1), m_hc[1]);
         chk("miss_count0", int'(mc0), m_mc[0]); chk("miss_count1", int'(mc1), m_mc[1]);
         chk("streak0", int'(st0), m_st[0]);    chk("streak1", int'(st1), m_st[1]);
         chk("max_streak0", int'(mx0), m_mx[0]); chk("max_streak1", int'(mx1), m_mx[1]);
         chk("level0", int'(lv0), m_lv[0]);     chk("level1", int'(lv1), m_lv[1]);
         chk("grade0", int'(gr0), m_gr[0]);     chk("grade1", int'(gr1), m_gr[1]);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic step(input bit nv, input int ne, input bit kv, input int kc, input bit sd);
      note_valid = nv; note_exp = 4'(ne);
      key_valid  = kv; key_code = 4'(kc);
      song_done  = sd;
      @(negedge clk);
      note_valid = 1'b0; key_valid = 1'b0; song_done = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic hit_note(input int n);
      step(1, n, 0, 0, 0);
      step(0, 0, 1, n, 0);
   endtask

   task automatic miss_note(input int n);
      step(1, n, 0, 0, 0);
      step(0, 0, 1, (n + 1) % 16, 0);
   endtask

   initial begin
      do_reset();
      started = 1'b1;
      chk("lit_reset_hc", int'(hc0), 0);
      chk("lit_reset_busy", int'(busy0), 0);
      chk("lit_reset_grade", int'(gr0), 0);

      // basic hit, key 10 clocks after the note
      step(1, 3, 0, 0, 0);
      idle(9);
      step(0, 0, 1, 3, 0);
      chk("lit_s1_hit", int'(hit0), 1);
      chk("lit_s1_hc", int'(hc0), 1);
      chk("lit_s1_streak", int'(st0), 1);
      chk("lit_s1_busy", int'(busy0), 0);
      idle(1);
      chk("lit_s1_pulse_end", int'(hit0), 0);

      // wrong key, then timeout on the 16th cycle, then key on the last window cycle
      step(1, 5, 0, 0, 0);
      step(0, 0, 1, 2, 0);
      chk("lit_s2_miss", int'(miss0), 1);
      chk("lit_s2_mc", int'(mc0), 1);
      chk("lit_s2_streak", int'(st0), 0);
      step(1, 1, 0, 0, 0);
      idle(15);
      chk("lit_s2_still_busy", int'(busy0), 1);
      chk("lit_s2_no_miss_yet", int'(miss0), 0);
      idle(1);
      chk("lit_s2_timeout", int'(miss0), 1);
      chk("lit_s2_mc2", int'(mc0), 2);
      step(1, 9, 0, 0, 0);
      idle(15);
      step(0, 0, 1, 9, 0);
      chk("lit_s2_edge_hit", int'(hit0), 1);
      chk("lit_s2_edge_mc", int'(mc0), 2);

      // streak levels and 3-bit saturation
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         hit_note(i % 16);
         if (i == 8)  chk("lit_s3_level1", int'(lv0), 1);
         if (i == 16) chk("lit_s3_level2", int'(lv0), 2);
      end
      chk("lit_s3_hc_sat", int'(hc1), 7);
      chk("lit_s3_st_sat", int'(st1), 7);
      chk("lit_s3_lv_narrow", int'(lv1), 0);
      miss_note(0);
      repeat (7) hit_note(3);
      chk("lit_s3_level_hold", int'(lv0), 2);
      chk("lit_s3_max", int'(mx0), 16);

      // note replaced before judgement; note+key on the same cycle
      do_reset();
      step(1, 4, 0, 0, 0);
      idle(2);
      step(1, 6, 0, 0, 0);
      chk("lit_s4_replace_miss", int'(miss0), 1);
      step(0, 0, 1, 6, 0);
      chk("lit_s4_hc", int'(hc0), 1);
      chk("lit_s4_mc", int'(mc0), 1);
      step(1, 5, 1, 5, 0);
      chk("lit_s4_key_ignored", int'(hit0), 0);
      step(0, 0, 1, 5, 0);
      chk("lit_s4_hit_later", int'(hit0), 1);

      // grading
      do_reset();
      repeat (6) hit_note(2);
      repeat (2) miss_note(4);
      step(0, 0, 0, 0, 1);
      chk("lit_s5_grade_late", int'(gr0), 0);
      idle(1);
      chk("lit_s5_grade_a", int'(gr0), 4);
      step(1, 2, 1, 2, 1);
      idle(2);
      chk("lit_s5_done_hold", int'(hc0), 6);
      do_reset();
      step(0, 0, 0, 0, 1);
      idle(1);
      chk("lit_s5_grade_none", int'(gr0), 0);
      do_reset();
      step(1, 2, 0, 0, 0);
      step(0, 0, 1, 2, 1);
      chk("lit_s5_key_then_done", int'(hit0), 1);
      idle(1);
      chk("lit_s5_grade_s", int'(gr0), 5);
      do_reset();
      hit_note(1);
      step(1, 4, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      chk("lit_s5_pending_miss", int'(miss0), 1);
      idle(1);
      chk("lit_s5_grade_b", int'(gr0), 3);

      // reset while a note is pending, with a matching key on the same edge
      do_reset();
      hit_note(7);
      step(1, 7, 0, 0, 0);
      idle(2);
      rst = 1'b1; key_valid = 1'b1; key_code = 4'd7;
      @(negedge clk);
      rst = 1'b0; key_valid = 1'b0;
      chk("lit_s6_no_hit", int'(hit0), 0);
      chk("lit_s6_hc", int'(hc0), 0);
      chk("lit_s6_busy", int'(busy0), 0);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
